fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one FIFO write port (DEPTH entries) between NUM_REQ producers.
- Supports bounded bursts: the winning requester keeps the port for up to BURST_MAX accepted beats.
- Asserts write_en only when the FIFO can accept the beat, so every asserted write_en is a committed write. The existing FIFO scoreboard binding therefore sees exactly the granted beats.
- Keeps a mirrored fill level for status.

---
 rtl/fifo_wr_arbiter_if.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO side bundle for fifo_wr_arbiter: requests, grant, FIFO write port and status.
// master = arbiter, slave = producers + FIFO environment.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int FLW = $clog2(DEPTH + 1);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          write_en;
    logic [DATA_WIDTH-1:0]         write_data;
    logic                          full;
    logic                          empty;
    logic                          read_en;
    logic                          owner_vld;
    logic [IDW-1:0]                owner_id;
    logic [FLW-1:0]                fill_level;

    modport master (
        input  req, req_data, full, empty, read_en,
        output gnt, write_en, write_data, owner_vld, owner_id, fill_level
    );

    modport slave (
        output req, req_data, full, empty, read_en,
        input  gnt, write_en, write_data, owner_vld, owner_id, fill_level
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin FIFO write-port arbiter with bounded bursts and a mirrored fill level.
// Optional per-producer grant counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                   clk,
    input  logic                   rstN,
    fifo_wr_arbiter_if.master      bus
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [NUM_REQ*16-1:0]  beat_count
`endif
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int FLW = $clog2(DEPTH + 1);
    localparam int BCW = $clog2(BURST_MAX + 1);

    typedef enum logic {ARB, BURST} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr, rr_nxt;
    logic [IDW-1:0] owner_id, owner_nxt;
    logic           owner_vld, owner_vld_nxt;
    logic [BCW-1:0] beat_cnt, beat_nxt, beat_inc;
    logic [FLW-1:0] fill_level;

    logic           space;
    logic           cand_vld;
    logic [IDW-1:0] cand;
    logic           fire;
    logic [IDW-1:0] gidx;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    assign space    = !bus.full || bus.read_en;
    assign beat_inc = beat_cnt + 1'b1;

    // Scan downward so the requester closest to rr_ptr is the last (winning) write.
    always_comb begin
        int idx;
        cand_vld = 1'b0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (bus.req[idx]) begin
                cand_vld = 1'b1;
                cand     = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= ARB;
            rr_ptr    <= '0;
            owner_id  <= '0;
            owner_vld <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            owner_id  <= owner_nxt;
            owner_vld <= owner_vld_nxt;
            beat_cnt  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_nxt        = rr_ptr;
        owner_nxt     = owner_id;
        owner_vld_nxt = owner_vld;
        beat_nxt      = beat_cnt;
        case (state)
            ARB: begin
                if (cand_vld && space) begin
                    owner_nxt = cand;
                    beat_nxt  = BCW'(1);
                    if (BURST_MAX > 1) begin
                        state_nxt     = BURST;
                        owner_vld_nxt = 1'b1;
                    end else begin
                        rr_nxt = next_id(cand);
                    end
                end
            end
            BURST: begin
                // A dropped request ends the burst; a stalled one (no space) keeps it.
                if (!bus.req[owner_id]) begin
                    state_nxt     = ARB;
                    owner_vld_nxt = 1'b0;
                    rr_nxt        = next_id(owner_id);
                end else if (space) begin
                    beat_nxt = beat_inc;
                    if (beat_inc == BCW'(BURST_MAX)) begin
                        state_nxt     = ARB;
                        owner_vld_nxt = 1'b0;
                        rr_nxt        = next_id(owner_id);
                    end
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        fire           = 1'b0;
        gidx           = cand;
        bus.gnt        = '0;
        bus.write_data = '0;
        case (state)
            ARB: begin
                fire = cand_vld && space;
                gidx = cand;
            end
            BURST: begin
                fire = bus.req[owner_id] && space;
                gidx = owner_id;
            end
            default: fire = 1'b0;
        endcase
        if (rstN && fire) begin
            bus.gnt[gidx]  = 1'b1;
            bus.write_data = bus.req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.write_en   = |bus.gnt;
    assign bus.owner_vld  = owner_vld;
    assign bus.owner_id   = owner_id;
    assign bus.fill_level = fill_level;

    // Reads of an empty FIFO only count when the same-cycle write feeds them.
    logic wr_acc, rd_acc;
    assign wr_acc = bus.write_en;
    assign rd_acc = bus.read_en && (!bus.empty || bus.write_en);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fill_level <= '0;
        end else if (wr_acc && !rd_acc && fill_level != FLW'(DEPTH)) begin
            fill_level <= fill_level + 1'b1;
        end else if (rd_acc && !wr_acc && fill_level != '0) begin
            fill_level <= fill_level - 1'b1;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN)                             cnt <= '0;
            else if (stats_clr)                    cnt <= '0;
            else if (bus.gnt[i] && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
        end
        assign beat_count[i*16 +: 16] = cnt;
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter (NUM_REQ=4, DEPTH=8, BURST_MAX=4).
module tb_fifo_wr_arbiter;
    localparam int NR = 4, DW = 32, DP = 8, BM = 4;
    localparam logic [31:0] D1 = 32'h2222_2222;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DP)) bus();

`ifdef FIFO_ARB_STATS_EN
    logic              stats_clr;
    logic [NR*16-1:0]  beat_count;
`endif

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DP), .BURST_MAX(BM)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .bus        (bus)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .beat_count (beat_count)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] d1;
        logic        full, empty, rd;
        logic [3:0]  gnt;
        logic        we;
        logic [31:0] wd;
        logic        ovld;
        logic [1:0]  oid;
        logic [3:0]  fill;
    } vec_t;

    vec_t vq[$];
    int total = 0;
    int bad   = 0;

    function automatic void add(input logic rst, input logic [3:0] req, input logic [31:0] d1,
                                input logic full, input logic empty, input logic rd,
                                input logic [3:0] gnt, input logic we, input logic [31:0] wd,
                                input logic ovld, input logic [1:0] oid, input logic [3:0] fill);
        vec_t v;
        v.rst = rst; v.req = req; v.d1 = d1; v.full = full; v.empty = empty; v.rd = rd;
        v.gnt = gnt; v.we = we; v.wd = wd; v.ovld = ovld; v.oid = oid; v.fill = fill;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] req, input logic [31:0] d1,
                          input logic full, input logic empty, input logic rd);
        bus.req      = req;
        bus.req_data = {32'h4444_4444, 32'h3333_3333, d1, 32'h1111_1111};
        bus.full     = full;
        bus.empty    = empty;
        bus.read_en  = rd;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        set_in(4'b0000, D1, 1'b0, 1'b1, 1'b0);
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #1;
        chk("rst_gnt",  32'(bus.gnt), 32'h0);
        chk("rst_we",   32'(bus.write_en), 32'h0);
        chk("rst_ovld", 32'(bus.owner_vld), 32'h0);
        chk("rst_fill", 32'(bus.fill_level), 32'h0);
        @(posedge clk); #1;
        rstN = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        if (v.rst) do_reset();
        set_in(v.req, v.d1, v.full, v.empty, v.rd);
        #3;
        chk($sformatf("v%0d_gnt", n),  32'(bus.gnt), 32'(v.gnt));
        chk($sformatf("v%0d_we", n),   32'(bus.write_en), 32'(v.we));
        chk($sformatf("v%0d_wd", n),   bus.write_data, v.wd);
        @(posedge clk); #1;
        chk($sformatf("v%0d_ovld", n), 32'(bus.owner_vld), 32'(v.ovld));
        chk($sformatf("v%0d_oid", n),  32'(bus.owner_id), 32'(v.oid));
        chk($sformatf("v%0d_fill", n), 32'(bus.fill_level), 32'(v.fill));
    endtask

    initial begin
        // Full contention with pass-through reads: bursts of 4 rotate 0,1,2,3,0.
        for (int b = 0; b < 17; b++) begin
            int idx;
            idx = (b / 4) % 4;
            add(b == 0, 4'hF, D1, 1'b0, 1'b1, 1'b1, 4'(1 << idx), 1'b1,
                32'h1111_1111 * (idx + 1), (b % 4) != 3, 2'(idx), 4'd0);
        end
        // Single producer fills the FIFO, then stalls on full.
        add(1, 4'b0100, D1, 0, 1, 0, 4'b0100, 1, 32'h3333_3333, 1, 2'd2, 4'd1);
        add(0, 4'b0100, D1, 0, 0, 0, 4'b0100, 1, 32'h3333_3333, 1, 2'd2, 4'd2);
        add(0, 4'b0100, D1, 0, 0, 0, 4'b0100, 1, 32'h3333_3333, 1, 2'd2, 4'd3);
        add(0, 4'b0100, D1, 0, 0, 0, 4'b0100, 1, 32'h3333_3333, 0, 2'd2, 4'd4);
        add(0, 4'b0100, D1, 0, 0, 0, 4'b0100, 1, 32'h3333_3333, 1, 2'd2, 4'd5);
        add(0, 4'b0100, D1, 0, 0, 0, 4'b0100, 1, 32'h3333_3333, 1, 2'd2, 4'd6);
        add(0, 4'b0100, D1, 0, 0, 0, 4'b0100, 1, 32'h3333_3333, 1, 2'd2, 4'd7);
        add(0, 4'b0100, D1, 0, 0, 0, 4'b0100, 1, 32'h3333_3333, 0, 2'd2, 4'd8);
        add(0, 4'b0100, D1, 1, 0, 0, 4'b0000, 0, 32'h0,         0, 2'd2, 4'd8);
        add(0, 4'b0100, D1, 1, 0, 0, 4'b0000, 0, 32'h0,         0, 2'd2, 4'd8);
        // Full but reading: write still granted, level pinned at DEPTH.
        add(0, 4'b0010, 32'hDEAD_BEEF, 1, 0, 1, 4'b0010, 1, 32'hDEAD_BEEF, 1, 2'd1, 4'd8);
        // Burst stalled by no space keeps ownership.
        add(0, 4'b0010, 32'hDEAD_BEEF, 1, 0, 0, 4'b0000, 0, 32'h0, 1, 2'd1, 4'd8);
        // Owner drops after 2 beats; next arbitration starts at 1 so 3 beats 0.
        add(1, 4'b1001, D1, 0, 1, 1, 4'b0001, 1, 32'h1111_1111, 1, 2'd0, 4'd0);
        add(0, 4'b1001, D1, 0, 1, 1, 4'b0001, 1, 32'h1111_1111, 1, 2'd0, 4'd0);
        add(0, 4'b1000, D1, 0, 1, 1, 4'b0000, 0, 32'h0,         0, 2'd0, 4'd0);
        add(0, 4'b1001, D1, 0, 1, 1, 4'b1000, 1, 32'h4444_4444, 1, 2'd3, 4'd0);
        // Read of an empty FIFO saturates at 0; non-owners ignored during a stall.
        add(1, 4'b0000, D1, 0, 0, 1, 4'b0000, 0, 32'h0,         0, 2'd0, 4'd0);
        add(0, 4'b0100, D1, 0, 1, 0, 4'b0100, 1, 32'h3333_3333, 1, 2'd2, 4'd1);
        add(0, 4'b0101, D1, 1, 0, 0, 4'b0000, 0, 32'h0,         1, 2'd2, 4'd1);
        add(0, 4'b0101, D1, 0, 0, 0, 4'b0100, 1, 32'h3333_3333, 1, 2'd2, 4'd2);
        // Lead-in for mid-burst reset: owner 1, two beats.
        add(1, 4'b0010, D1, 0, 1, 1, 4'b0010, 1, 32'h2222_2222, 1, 2'd1, 4'd0);
        add(0, 4'b0010, D1, 0, 1, 1, 4'b0010, 1, 32'h2222_2222, 1, 2'd1, 4'd0);

        for (int n = 0; n < vq.size(); n++) run_vec(vq[n], n);

        // Mid-burst reset: outputs drop at once even with req held.
        rstN = 1'b0;
        #1;
        chk("mrst_gnt",  32'(bus.gnt), 32'h0);
        chk("mrst_we",   32'(bus.write_en), 32'h0);
        chk("mrst_wd",   bus.write_data, 32'h0);
        chk("mrst_ovld", 32'(bus.owner_vld), 32'h0);
        @(posedge clk); #1;
        rstN = 1'b1;
        set_in(4'b1010, D1, 1'b0, 1'b1, 1'b1);
        #3;
        chk("mrst_rel_gnt", 32'(bus.gnt), 32'h2);
        chk("mrst_rel_wd",  bus.write_data, 32'h2222_2222);
        @(posedge clk); #1;
        chk("mrst_rel_oid",  32'(bus.owner_id), 32'h1);
        chk("mrst_rel_ovld", 32'(bus.owner_vld), 32'h1);

`ifdef FIFO_ARB_STATS_EN
        do_reset();
        set_in(4'b1000, D1, 1'b0, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("stat3_pre", 32'(beat_count[3*16 +: 16]), 32'd5);
        chk("stat0_pre", 32'(beat_count[0 +: 16]), 32'd0);
        stats_clr = 1'b1;
        #3;
        chk("stat_clr_gnt", 32'(bus.gnt), 32'h8);
        @(posedge clk); #1;
        stats_clr = 1'b0;
        chk("stat3_clr", 32'(beat_count[3*16 +: 16]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
